// File: rtl/axi4_lite_if_pkg.sv
// AXI4-Lite shared definitions.
// Response codes and arbiter FSM states.
package axi4_lite_if_pkg;

  localparam logic [1:0] AXI4_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R
  } arb_state_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle.
// Master and slave views of the five channels.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport mst_port (
    output awvalid, awaddr, awprot,
    input  awready,
    output wvalid, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arprot,
    input  arready,
    input  rvalid, rdata, rresp,
    output rready
  );

  modport slv_port (
    input  awvalid, awaddr, awprot,
    output awready,
    input  wvalid, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arprot,
    output arready,
    output rvalid, rdata, rresp,
    input  rready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant.
// Search starts at the pointer; pointer moves past the winner on accept.
module rr_arbiter #(
  parameter  int N_REQ = 2,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    gnt_idx,
  output logic             any,
  output logic [PW-1:0]    ptr
);

  int j;

  // first requester at or after ptr, wrapping
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  // pointer advances to winner+1 mod N_REQ
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      if (gnt_idx == PW'(N_REQ - 1)) ptr <= '0;
      else                           ptr <= gnt_idx + PW'(1);
    end
  end

endmodule

// File: rtl/axi4_lite_rr_mst_arbiter.sv
// Round-robin sharing of one AXI4-Lite master port.
// One transaction in flight; all bus outputs registered.
module axi4_lite_rr_mst_arbiter
  import axi4_lite_if_pkg::*;
#(
  parameter  int N_REQ                    = 2,
  parameter  int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter  int AXI4_LITE_DATA_BIT_WIDTH = 32,
  localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH,
  localparam int DW = AXI4_LITE_DATA_BIT_WIDTH,
  localparam int SW = DW / 8,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_sync_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ-1:0]          i_req_is_wr,
  input  logic [N_REQ-1:0][AW-1:0]  i_req_addr,
  input  logic [N_REQ-1:0][DW-1:0]  i_req_wdata,
  input  logic [N_REQ-1:0][SW-1:0]  i_req_wstrb,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [DW-1:0]             o_rsp_rdata,
  output logic [1:0]                o_rsp_resp,
  axi4_lite_if.mst_port             if_m_axi4_lite
);

  arb_state_t state_q, state_n;

  logic awvalid_q, awvalid_n;
  logic wvalid_q, wvalid_n;
  logic arvalid_q, arvalid_n;
  logic bready_q, bready_n;
  logic rready_q, rready_n;
  logic aw_done_q, aw_done_n;
  logic w_done_q, w_done_n;

  logic [AW-1:0] awaddr_q, awaddr_n;
  logic [AW-1:0] araddr_q, araddr_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic [SW-1:0] wstrb_q, wstrb_n;
  logic [PW-1:0] owner_q, owner_n;

  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_n;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_n;
  logic [1:0]       rsp_resp_q, rsp_resp_n;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    rr_ptr;
  logic             any;
  logic             accept;

  assign accept = (state_q == IDLE) && any && !i_sync_rst;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk     (i_clk),
    .rst     (i_sync_rst),
    .req     (i_req_valid),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any),
    .ptr     (rr_ptr)
  );

  assign o_req_ready = {N_REQ{accept}} & gnt;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_resp  = rsp_resp_q;

  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.awaddr  = awaddr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.araddr  = araddr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.rready  = rready_q;

  // next-state and next-output decode
  always_comb begin
    state_n     = state_q;
    awvalid_n   = awvalid_q;
    wvalid_n    = wvalid_q;
    arvalid_n   = arvalid_q;
    bready_n    = bready_q;
    rready_n    = rready_q;
    aw_done_n   = aw_done_q;
    w_done_n    = w_done_q;
    awaddr_n    = awaddr_q;
    araddr_n    = araddr_q;
    wdata_n     = wdata_q;
    wstrb_n     = wstrb_q;
    owner_n     = owner_q;
    rsp_valid_n = '0;
    rsp_rdata_n = rsp_rdata_q;
    rsp_resp_n  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_n = gnt_idx;
          if (i_req_is_wr[gnt_idx]) begin
            awaddr_n  = i_req_addr[gnt_idx];
            wdata_n   = i_req_wdata[gnt_idx];
            wstrb_n   = i_req_wstrb[gnt_idx];
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WR_AW_W;
          end else begin
            araddr_n  = i_req_addr[gnt_idx];
            arvalid_n = 1'b1;
            state_n   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        if (awvalid_q && if_m_axi4_lite.awready) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (wvalid_q && if_m_axi4_lite.wready) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WR_B;
        end
      end
      WR_B: begin
        if (if_m_axi4_lite.bvalid && bready_q) begin
          rsp_resp_n           = if_m_axi4_lite.bresp;
          rsp_valid_n[owner_q] = 1'b1;
          bready_n             = 1'b0;
          state_n              = IDLE;
        end
      end
      RD_AR: begin
        if (arvalid_q && if_m_axi4_lite.arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_R;
        end
      end
      RD_R: begin
        if (if_m_axi4_lite.rvalid && rready_q) begin
          rsp_rdata_n          = if_m_axi4_lite.rdata;
          rsp_resp_n           = if_m_axi4_lite.rresp;
          rsp_valid_n[owner_q] = 1'b1;
          rready_n             = 1'b0;
          state_n              = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q     <= IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI4_RESP_OKAY;
    end else begin
      state_q     <= state_n;
      awvalid_q   <= awvalid_n;
      wvalid_q    <= wvalid_n;
      arvalid_q   <= arvalid_n;
      bready_q    <= bready_n;
      rready_q    <= rready_n;
      aw_done_q   <= aw_done_n;
      w_done_q    <= w_done_n;
      awaddr_q    <= awaddr_n;
      araddr_q    <= araddr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      owner_q     <= owner_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_resp_q  <= rsp_resp_n;
    end
  end

endmodule
